// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: EX-stage multi-cycle multiply/divide sequencer and owner of
// the architectural HI/LO registers. Runs a shift-add multiplier or restoring
// divider over DATA_W iterations, then applies sign correction in FIXUP.
// Optional feature macro: MULDIV_EARLY_OUT_EN (divide with |dividend| <
// |divisor| skips CALC and finishes through FIXUP directly).
module ex_muldiv_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        Op,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic              HiLoRead,
  input  logic              Flush,
  output logic              Stall,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // acc holds {product_hi, multiplier/product_lo} or {remainder, quotient}
  logic [2*DATA_W-1:0] acc_q, acc_d;
  // opb holds the multiplicand magnitude or the divisor magnitude
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic                is_div_q, is_div_d;
  logic                neg_lo_q, neg_lo_d;   // negate product / quotient
  logic                neg_hi_q, neg_hi_d;   // remainder takes dividend sign
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  // Operation decode
  logic op_mul, op_div, op_signed, op_hilo;
  assign op_mul    = (Op == OP_MULT) || (Op == OP_MULTU);
  assign op_div    = (Op == OP_DIV)  || (Op == OP_DIVU);
  assign op_signed = (Op == OP_MULT) || (Op == OP_DIV);
  assign op_hilo   = (Op != 3'b000) && (Op != 3'b111);

  // Operand magnitudes: two's-complement absolute value for signed ops
  logic [DATA_W-1:0] abs_a, abs_b;
  logic              divisor_zero;
  assign abs_a        = (op_signed && ReadData1[DATA_W-1]) ? -ReadData1 : ReadData1;
  assign abs_b        = (op_signed && ReadData2[DATA_W-1]) ? -ReadData2 : ReadData2;
  assign divisor_zero = (ReadData2 == '0);

  // One shift-add multiply step: conditionally add, then shift right with carry
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

  // One restoring divide step: shift in next dividend bit, trial subtract.
  // The partial remainder is always below the divisor, so the low DATA_W bits
  // of the difference are exact whenever the trial succeeds.
  logic [DATA_W:0]     div_shift;
  logic                div_ge;
  logic [DATA_W-1:0]   div_sub;
  logic [2*DATA_W-1:0] div_next;
  assign div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_sub   = div_shift[DATA_W-1:0] - opb_q;
  assign div_next  = div_ge ? {div_sub, acc_q[DATA_W-2:0], 1'b1}
                            : {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};

  // Sign-corrected results; divide by zero leaves |dividend| in the remainder
  // half and all ones in the quotient, so re-applying the dividend sign to the
  // remainder returns the dividend as issued.
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   rem_fix, quo_fix;
  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign rem_fix  = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
  assign quo_fix  = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];

  // Next-state and datapath update
  // NOTE: every _d gets a default first so no path through the case can leave
  // it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (Flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (op_mul || op_div) begin
            is_div_d = op_div;
            opb_d    = op_div ? abs_b : abs_a;
            acc_d    = {{DATA_W{1'b0}}, (op_div ? abs_a : abs_b)};
            // Quotient of a divide by zero stays all ones, never negated
            neg_lo_d = op_signed && (ReadData1[DATA_W-1] ^ ReadData2[DATA_W-1])
                       && (op_mul || !divisor_zero);
            neg_hi_d = op_signed && op_div && ReadData1[DATA_W-1];
            cnt_d    = '0;
            state_d  = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
            if (op_div && !divisor_zero && (abs_a < abs_b)) begin
              acc_d   = {abs_a, {DATA_W{1'b0}}};
              state_d = S_FIXUP;
            end
`endif
          end else if (Op == OP_MTHI) begin
            hi_d = ReadData1;
          end else if (Op == OP_MTLO) begin
            lo_d = ReadData1;
          end
        end
        S_CALC: begin
          cnt_d = cnt_q + 1'b1;
          acc_d = is_div_q ? div_next : mul_next;
          if (cnt_q == LAST_ITER) state_d = S_FIXUP;
        end
        S_FIXUP: begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, datapath and HI/LO registers
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value regardless of statement order.
  // NOTE: the accumulator and operand registers are reset too, so a unit that
  // leaves reset never exposes X on its internal datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign Busy  = (state_q != S_IDLE);
  assign Done  = (state_q == S_FIXUP) && !Flush;
  assign Stall = Busy && (HiLoRead || op_hilo);
  assign Hi    = hi_q;
  assign Lo    = lo_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: scoreboard of expected {Hi,Lo}
// pushed at issue and popped when the unit reports completion.
module tb_ex_muldiv_ctrl;

  localparam int W = 32;
  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic          clk;
  logic          rst_n;
  logic [2:0]    Op;
  logic [W-1:0]  ReadData1, ReadData2;
  logic          HiLoRead, Flush;
  logic          Stall, Busy, Done;
  logic [W-1:0]  Hi, Lo;

  int checks;
  int errors;
  logic [2*W-1:0] sb_q[$];
  logic [W-1:0]   last_hi, last_lo;

  ex_muldiv_ctrl #(.DATA_W(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .ReadData1(ReadData1),
    .ReadData2(ReadData2), .HiLoRead(HiLoRead), .Flush(Flush),
    .Stall(Stall), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mag(input logic [2:0] op, input logic [W-1:0] v);
    if ((op == OP_MULT || op == OP_DIV) && v[W-1]) return -v;
    return v;
  endfunction

  function automatic bit early_out(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    return (op == OP_DIV || op == OP_DIVU) && (b != 0) && (mag(op, a) < mag(op, b));
`else
    return 1'b0;
`endif
  endfunction

  // Reference result {Hi,Lo} from native arithmetic
  function automatic logic [2*W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    int ia, ib, q, r;
    logic [W-1:0] qv, rv;
    case (op)
      OP_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      OP_MULTU: return {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        ia = $signed(a);
        ib = $signed(b);
        q = ia / ib;
        r = ia % ib;
        qv = q;
        rv = r;
        return {rv, qv};
      end
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return '0;
    endcase
  endfunction

  // Issue one MULT/DIV, track Done timing and Stall count, compare result
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input logic hl, input string name);
    int lat, cyc, stalls;
    logic [2*W-1:0] want;
    lat = early_out(op, a, b) ? 1 : W + 1;
    sb_q.push_back(exp);
    @(negedge clk);
    Op = op; ReadData1 = a; ReadData2 = b;
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      errors++; $display("FAIL %s accept_stall got %b want 0", name, Stall);
    end
    @(negedge clk);
    Op = OP_NONE; HiLoRead = hl;
    cyc = 1; stalls = 0;
    while (cyc <= 100) begin
      #1;
      if (Stall === 1'b1) stalls++;
      if (Done === 1'b1) break;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != lat) begin
      errors++; $display("FAIL %s done_cycle got %0d want %0d", name, cyc, lat);
    end
    @(negedge clk);
    #1;
    checks++;
    if (stalls != (hl ? lat : 0)) begin
      errors++; $display("FAIL %s stall_cycles got %0d want %0d", name, stalls, hl ? lat : 0);
    end
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Stall !== 1'b0) begin
      errors++; $display("FAIL %s after_done busy/done/stall got %b%b%b want 000", name, Busy, Done, Stall);
    end
    want = sb_q.pop_front();
    checks++;
    if ({Hi, Lo} !== want) begin
      errors++; $display("FAIL %s hilo got %h_%h want %h_%h", name, Hi, Lo, want[63:32], want[31:0]);
    end
    last_hi = want[63:32];
    last_lo = want[31:0];
    HiLoRead = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Op = OP_MULT; ReadData1 = 32'd5; ReadData2 = 32'd6;
    HiLoRead = 1'b1; Flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (Hi !== 0 || Lo !== 0 || Busy !== 0 || Done !== 0 || Stall !== 0) begin
      errors++; $display("FAIL reset hi=%h lo=%h busy=%b done=%b stall=%b want all 0", Hi, Lo, Busy, Done, Stall);
    end
    Op = OP_NONE; HiLoRead = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (Busy !== 0 || Hi !== 0) begin
      errors++; $display("FAIL reset_release busy=%b hi=%h want 0", Busy, Hi);
    end
    last_hi = '0; last_lo = '0;
  endtask

  task automatic test_mult();
    run_op(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 1'b1, "mult_neg2x3");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b0, "multu_max");
  endtask

  task automatic test_div();
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, "div_neg7by2");
    run_op(OP_DIVU, 32'd7,         32'd0,         {32'd7,         32'hFFFF_FFFF}, 1'b0, "divu_by_zero");
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd0,         {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b0, "div_neg_by_zero");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, {32'h0,         32'h8000_0000}, 1'b0, "div_overflow");
    run_op(OP_DIVU, 32'd3,         32'd10,        {32'd3,         32'd0},         1'b0, "divu_3by10");
    run_op(OP_DIV,  32'hFFFF_FFFD, 32'd10,        {32'hFFFF_FFFD, 32'd0},         1'b0, "div_neg3by10");
  endtask

  task automatic test_flush_calc();
    int cyc, dones;
    @(negedge clk);
    Op = OP_DIVU; ReadData1 = 32'd100; ReadData2 = 32'd7;
    @(negedge clk);
    Op = OP_NONE; cyc = 1; dones = 0;
    while (cyc < 10) begin
      #1; if (Done === 1'b1) dones++;
      @(negedge clk); cyc++;
    end
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0; Op = OP_MTHI; ReadData1 = 32'h0000_1234;
    #1;
    checks++;
    if (Busy !== 1'b0 || Stall !== 1'b0) begin
      errors++; $display("FAIL flush_calc busy/stall got %b%b want 00", Busy, Stall);
    end
    checks++;
    if (Hi !== last_hi || Lo !== last_lo) begin
      errors++; $display("FAIL flush_calc hilo got %h_%h want %h_%h", Hi, Lo, last_hi, last_lo);
    end
    @(negedge clk);
    Op = OP_NONE;
    repeat (40) begin
      #1; if (Done === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (Hi !== 32'h0000_1234 || Lo !== last_lo) begin
      errors++; $display("FAIL mthi_after_flush got %h_%h want 00001234_%h", Hi, Lo, last_lo);
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL flush_calc done_pulses got %0d want 0", dones);
    end
    last_hi = 32'h0000_1234;
  endtask

  task automatic test_flush_fixup();
    int cyc;
    @(negedge clk);
    Op = OP_MULTU; ReadData1 = 32'd5; ReadData2 = 32'd6;
    @(negedge clk);
    Op = OP_NONE; cyc = 1;
    while (cyc <= 100) begin
      #1; if (Done === 1'b1) break;
      @(negedge clk); cyc++;
    end
    Flush = 1'b1;
    #1;
    checks++;
    if (Done !== 1'b0) begin
      errors++; $display("FAIL flush_fixup done got %b want 0", Done);
    end
    @(negedge clk);
    Flush = 1'b0;
    #1;
    checks++;
    if (Hi !== last_hi || Lo !== last_lo || Busy !== 1'b0) begin
      errors++; $display("FAIL flush_fixup hilo/busy got %h_%h/%b want %h_%h/0", Hi, Lo, Busy, last_hi, last_lo);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    Op = OP_MTHI; ReadData1 = 32'hAAAA_0001;
    @(negedge clk);
    Op = OP_MTLO; ReadData1 = 32'h5555_0002;
    #1;
    checks++;
    if (Stall !== 1'b0 || Hi !== 32'hAAAA_0001) begin
      errors++; $display("FAIL b2b_mthi stall/hi got %b/%h want 0/aaaa0001", Stall, Hi);
    end
    @(negedge clk);
    Op = OP_NONE;
    #1;
    checks++;
    if (Hi !== 32'hAAAA_0001 || Lo !== 32'h5555_0002) begin
      errors++; $display("FAIL b2b_mtlo got %h_%h want aaaa0001_55550002", Hi, Lo);
    end
    last_hi = 32'hAAAA_0001; last_lo = 32'h5555_0002;
  endtask

  // Op presented while busy stalls, then is taken in the first idle cycle
  task automatic test_stall_replay();
    int cyc, stalls, lat;
    logic [2*W-1:0] want;
    sb_q.push_back({32'h0, 32'd6});
    sb_q.push_back({32'd2, 32'd3});
    lat = early_out(OP_DIVU, 32'd20, 32'd6) ? 1 : W + 1;
    @(negedge clk);
    Op = OP_MULTU; ReadData1 = 32'd2; ReadData2 = 32'd3;
    @(negedge clk);
    Op = OP_DIVU; ReadData1 = 32'd20; ReadData2 = 32'd6;
    cyc = 1; stalls = 0;
    while (cyc <= 100) begin
      #1;
      if (Stall !== 1'b1) break;
      stalls++;
      @(negedge clk); cyc++;
    end
    checks++;
    if (stalls != W + 1) begin
      errors++; $display("FAIL replay stall_cycles got %0d want %0d", stalls, W + 1);
    end
    want = sb_q.pop_front();
    checks++;
    if ({Hi, Lo} !== want) begin
      errors++; $display("FAIL replay_mult hilo got %h_%h want %h_%h", Hi, Lo, want[63:32], want[31:0]);
    end
    @(negedge clk);
    Op = OP_NONE; cyc = 1;
    while (cyc <= 100) begin
      #1; if (Done === 1'b1) break;
      @(negedge clk); cyc++;
    end
    checks++;
    if (cyc != lat) begin
      errors++; $display("FAIL replay_div done_cycle got %0d want %0d", cyc, lat);
    end
    @(negedge clk);
    want = sb_q.pop_front();
    checks++;
    if ({Hi, Lo} !== want) begin
      errors++; $display("FAIL replay_div hilo got %h_%h want %h_%h", Hi, Lo, want[63:32], want[31:0]);
    end
    last_hi = want[63:32]; last_lo = want[31:0];
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom();
      b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
      if ($urandom_range(0, 1) == 1) a = a >> $urandom_range(0, 31);
      run_op(op, a, b, model(op, a, b), 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    Op = OP_DIVU; ReadData1 = 32'd100; ReadData2 = 32'd7;
    @(negedge clk);
    Op = OP_NONE;
    repeat (5) @(negedge clk);
    checks++;
    if (Busy !== 1'b1) begin
      errors++; $display("FAIL reset_mid busy_before got %b want 1", Busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (Hi !== 0 || Lo !== 0 || Busy !== 0 || Done !== 0) begin
      errors++; $display("FAIL reset_mid hi=%h lo=%h busy=%b done=%b want 0", Hi, Lo, Busy, Done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (Hi !== 0 || Lo !== 0 || Busy !== 0) begin
      errors++; $display("FAIL reset_mid_after hi=%h lo=%h busy=%b want 0", Hi, Lo, Busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mult();
    test_div();
    test_flush_calc();
    test_flush_fixup();
    test_back_to_back();
    test_stall_replay();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
